cpu_control_unit: RTL and testbench
===================================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port i_clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port o_fetch_req, output, 1, the program-memory read request.
REQ-005 The block SHALL have port o_pc, output, 8, the fetch address.
REQ-006 The block SHALL have port i_fetch_ack, input, 1, which marks i_instr valid this cycle.
REQ-007 The block SHALL have port i_instr, input, 8, the instruction or immediate byte.
REQ-008 The block SHALL have ports i_zr, i_ng, i_co, i_of, input, 1 each, the latched ALU flags.
REQ-009 The block SHALL have ports o_a_wrtn, o_a_rdn, o_b_wrtn, o_b_rdn, output, 1 each, the active-low register write and bus-drive strobes.
REQ-010 The block SHALL have ports o_alu_opcode (output, 4), o_cin (output, 1), o_alu_sel (output, 1, ALU drives bus) and o_alu_flag_sel (output, 1, latch flags).
REQ-011 The block SHALL have ports o_imm_data (output, 8) and o_imm_oe (output, 1, immediate drives bus).
REQ-012 The block SHALL have ports o_halted (output, 1) and o_illegal (output, 1, one-cycle pulse).

Function
REQ-013 The block SHALL implement states FETCH, FETCH_IMM, EXEC and HALT.
REQ-014 In FETCH and FETCH_IMM the block SHALL hold o_fetch_req=1 and keep o_pc stable until i_fetch_ack=1.
REQ-015 An ack in FETCH SHALL latch i_instr into IR and advance PC by 1, with 8'hFF wrapping to 8'h00.
- Next state is FETCH_IMM for two-byte opcodes and EXEC otherwise.
REQ-016 An ack in FETCH_IMM SHALL latch i_instr into IMM, advance PC by 1 (wrapping), and go to EXEC.
REQ-017 An ack arriving in the same cycle as the request SHALL be accepted, giving 2 cycles per 1-byte instruction and 3 per 2-byte instruction.
REQ-018 EXEC SHALL last exactly one cycle; all datapath strobes are asserted only in EXEC, and the next state is FETCH unless stated otherwise.
REQ-019 Outside EXEC, all strobes SHALL be inactive: wrtn/rdn=1, o_alu_sel=0, o_alu_flag_sel=0, o_imm_oe=0.
REQ-020 The block SHALL decode IR[7:4] as follows:
- 0x0 NOP: no strobes.
- 0x1 LDI (2-byte): o_imm_oe=1, o_imm_data=IMM; o_a_wrtn=0 if IR[0]=0, else o_b_wrtn=0.
- 0x2 MOV: IR[0]=0 gives o_b_rdn=0 and o_a_wrtn=0; IR[0]=1 gives o_a_rdn=0 and o_b_wrtn=0.
- 0x3 ALU: o_alu_opcode=IR[3:0], o_cin=0, o_alu_sel=1, o_alu_flag_sel=1, o_a_wrtn=0.
- 0x4 ALUC: same as 0x3 but o_cin=i_co.
- 0x5 JMP (2-byte): PC<=IMM.
- 0x6 JCC (2-byte): cond = {i_zr,i_ng,i_co,i_of}[IR[1:0]] (00=zr, 01=ng, 10=co, 11=of), XOR IR[2]; PC<=IMM if cond=1.
- 0xF HALT: go to HALT.
- 0x7..0xE: behave as NOP and pulse o_illegal=1 for the EXEC cycle.
REQ-021 At most one of o_imm_oe, o_alu_sel, o_a_rdn=0 and o_b_rdn=0 SHALL be active in any cycle.
REQ-022 o_alu_opcode and o_cin SHALL be 0 outside ALU/ALUC EXEC cycles.
REQ-023 JCC SHALL sample flags during its EXEC cycle, so the flags reflect the last completed ALU instruction.
REQ-024 HALT SHALL hold o_halted=1 with o_fetch_req=0 and no strobes, and is left only by reset.
REQ-025 A fetch request SHALL NOT be withdrawn before its ack; i_fetch_ack outside FETCH/FETCH_IMM SHALL be ignored.

Reset
REQ-026 While i_rst=1 the block SHALL immediately force:
- state=FETCH, PC=RESET_PC, IR=IMM=0;
- o_fetch_req=0;
- all wrtn/rdn=1, o_alu_sel=0, o_alu_flag_sel=0, o_imm_oe=0, o_alu_opcode=0, o_cin=0;
- o_halted=0, o_illegal=0.
REQ-027 The block SHALL assert o_fetch_req=1 in the first cycle after i_rst deasserts.
REQ-028 Reset asserted during EXEC or a pending fetch SHALL abort the instruction and suppress any strobe that cycle.

Verification
REQ-029 The bench SHALL cover: ack tied 1, program 0x10,0x5A -> EXEC cycle 3 shows o_imm_oe=1, o_imm_data=0x5A, o_a_wrtn=0; o_pc=0x02 after.
REQ-030 The bench SHALL cover: 0x35 with ack delayed 4 cycles -> o_pc held stable with o_fetch_req=1; EXEC shows o_alu_opcode=5, o_alu_sel=1, o_alu_flag_sel=1, o_a_wrtn=0, o_cin=0.
REQ-031 The bench SHALL cover: 0x60,0x20 with i_zr=1 -> PC=0x20; 0x64,0x20 with i_zr=1 -> PC=start+2.
REQ-032 The bench SHALL cover: RESET_PC=8'hFF, instr 0x00 -> o_pc wraps to 0x00; 0x50,0xFE at 0xFE -> PC=0xFE.
REQ-033 The bench SHALL cover: 0x80 -> o_illegal pulses exactly 1 cycle with no strobes; 0xF0 -> o_halted=1, no further o_fetch_req.
REQ-034 The bench SHALL cover: i_rst asserted mid-EXEC of 0x21 -> o_b_wrtn and o_a_rdn return to 1 the same cycle; o_pc=RESET_PC.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle control unit for an 8-bit accumulator CPU: fetches one- and two-byte
// instructions over a req/ack port and issues one cycle of datapath strobes per instruction.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_fetch_req,
  output logic [7:0] o_pc,
  input  logic       i_fetch_ack,
  input  logic [7:0] i_instr,
  input  logic       i_zr,
  input  logic       i_ng,
  input  logic       i_co,
  input  logic       i_of,
  output logic       o_a_wrtn,
  output logic       o_a_rdn,
  output logic       o_b_wrtn,
  output logic       o_b_rdn,
  output logic [3:0] o_alu_opcode,
  output logic       o_cin,
  output logic       o_alu_sel,
  output logic       o_alu_flag_sel,
  output logic [7:0] o_imm_data,
  output logic       o_imm_oe,
  output logic       o_halted,
  output logic       o_illegal
);

  typedef enum logic [1:0] {FETCH, FETCH_IMM, EXEC, HALT} state_e;

  typedef struct packed {
    logic       a_wrtn;
    logic       a_rdn;
    logic       b_wrtn;
    logic       b_rdn;
    logic [3:0] alu_opcode;
    logic       cin_en;
    logic       alu_sel;
    logic       alu_flag_sel;
    logic       imm_oe;
    logic [7:0] imm_data;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{a_wrtn: 1'b1, a_rdn: 1'b1, b_wrtn: 1'b1, b_rdn: 1'b1,
                                  alu_opcode: 4'h0, cin_en: 1'b0, alu_sel: 1'b0,
                                  alu_flag_sel: 1'b0, imm_oe: 1'b0, imm_data: 8'h00,
                                  illegal: 1'b0};

  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h5) || (op == 4'h6);
  endfunction

  function automatic ctrl_t decode(input logic [7:0] ir, input logic [7:0] imm);
    ctrl_t c;
    c = CTRL_IDLE;
    case (ir[7:4])
      4'h1: begin
        c.imm_oe   = 1'b1;
        c.imm_data = imm;
        if (ir[0]) c.b_wrtn = 1'b0;
        else       c.a_wrtn = 1'b0;
      end
      4'h2: begin
        if (ir[0]) begin
          c.a_rdn  = 1'b0;
          c.b_wrtn = 1'b0;
        end else begin
          c.b_rdn  = 1'b0;
          c.a_wrtn = 1'b0;
        end
      end
      4'h3, 4'h4: begin
        c.alu_opcode   = ir[3:0];
        c.cin_en       = (ir[7:4] == 4'h4);
        c.alu_sel      = 1'b1;
        c.alu_flag_sel = 1'b1;
        c.a_wrtn       = 1'b0;
      end
      4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       fetch_req_q, fetch_req_d;
  logic       halted_q, halted_d;
  ctrl_t      ctrl_q, ctrl_d;

  logic [3:0] flags;
  logic       accept;
  logic       jcc_taken;

  assign flags     = {i_zr, i_ng, i_co, i_of};
  assign accept    = fetch_req_q & i_fetch_ack;
  // Selector 00 picks zr, the MSB of the flag vector, hence the inverted index.
  assign jcc_taken = flags[~ir_q[1:0]] ^ ir_q[2];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    halted_d = halted_q;
    case (state_q)
      FETCH: if (accept) begin
        ir_d    = i_instr;
        pc_d    = pc_q + 8'd1;
        state_d = is_two_byte(i_instr[7:4]) ? FETCH_IMM : EXEC;
      end
      FETCH_IMM: if (accept) begin
        imm_d   = i_instr;
        pc_d    = pc_q + 8'd1;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (ir_q[7:4])
          4'h5: pc_d = imm_q;
          4'h6: if (jcc_taken) pc_d = imm_q;
          4'hF: begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end
      HALT: ;
    endcase
    fetch_req_d = (state_d == FETCH) || (state_d == FETCH_IMM);
    ctrl_d      = (state_d == EXEC) ? decode(ir_d, imm_d) : CTRL_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 8'h00;
      imm_q       <= 8'h00;
      fetch_req_q <= 1'b0;
      halted_q    <= 1'b0;
      ctrl_q      <= CTRL_IDLE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      fetch_req_q <= fetch_req_d;
      halted_q    <= halted_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign o_fetch_req    = fetch_req_q;
  assign o_pc           = pc_q;
  assign o_halted       = halted_q;
  assign o_a_wrtn       = ctrl_q.a_wrtn;
  assign o_a_rdn        = ctrl_q.a_rdn;
  assign o_b_wrtn       = ctrl_q.b_wrtn;
  assign o_b_rdn        = ctrl_q.b_rdn;
  assign o_alu_opcode   = ctrl_q.alu_opcode;
  assign o_alu_sel      = ctrl_q.alu_sel;
  assign o_alu_flag_sel = ctrl_q.alu_flag_sel;
  assign o_imm_oe       = ctrl_q.imm_oe;
  assign o_imm_data     = ctrl_q.imm_data;
  assign o_illegal      = ctrl_q.illegal;
  // Carry-in follows the live flag during the ALUC cycle rather than a stale copy.
  assign o_cin          = ctrl_q.cin_en & i_co;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack;
  logic [7:0] instr;
  logic [3:0] flags;  // {zr, ng, co, of}

  logic       o_fetch_req, o_a_wrtn, o_a_rdn, o_b_wrtn, o_b_rdn, o_cin;
  logic       o_alu_sel, o_alu_flag_sel, o_imm_oe, o_halted, o_illegal;
  logic [7:0] o_pc, o_imm_data;
  logic [3:0] o_alu_opcode;

  logic       ff_fetch_req, ff_a_wrtn, ff_a_rdn, ff_b_wrtn, ff_b_rdn, ff_cin;
  logic       ff_alu_sel, ff_alu_flag_sel, ff_imm_oe, ff_halted, ff_illegal;
  logic [7:0] ff_pc, ff_imm_data;
  logic [3:0] ff_alu_opcode;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] m_pc;

  localparam logic [12:0] IDLE = 13'b1111_0000_0_0_0_0_0;
  logic [12:0] ctrl_obs;
  assign ctrl_obs = {o_a_wrtn, o_a_rdn, o_b_wrtn, o_b_rdn, o_alu_opcode,
                     o_cin, o_alu_sel, o_alu_flag_sel, o_imm_oe, o_illegal};

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .i_clk(clk), .i_rst(rst), .o_fetch_req(o_fetch_req), .o_pc(o_pc),
    .i_fetch_ack(ack), .i_instr(instr),
    .i_zr(flags[3]), .i_ng(flags[2]), .i_co(flags[1]), .i_of(flags[0]),
    .o_a_wrtn(o_a_wrtn), .o_a_rdn(o_a_rdn), .o_b_wrtn(o_b_wrtn), .o_b_rdn(o_b_rdn),
    .o_alu_opcode(o_alu_opcode), .o_cin(o_cin), .o_alu_sel(o_alu_sel),
    .o_alu_flag_sel(o_alu_flag_sel), .o_imm_data(o_imm_data), .o_imm_oe(o_imm_oe),
    .o_halted(o_halted), .o_illegal(o_illegal)
  );

  cpu_control_unit #(.RESET_PC(8'hFF)) dut_ff (
    .i_clk(clk), .i_rst(rst), .o_fetch_req(ff_fetch_req), .o_pc(ff_pc),
    .i_fetch_ack(ack), .i_instr(instr),
    .i_zr(flags[3]), .i_ng(flags[2]), .i_co(flags[1]), .i_of(flags[0]),
    .o_a_wrtn(ff_a_wrtn), .o_a_rdn(ff_a_rdn), .o_b_wrtn(ff_b_wrtn), .o_b_rdn(ff_b_rdn),
    .o_alu_opcode(ff_alu_opcode), .o_cin(ff_cin), .o_alu_sel(ff_alu_sel),
    .o_alu_flag_sel(ff_alu_flag_sel), .o_imm_data(ff_imm_data), .o_imm_oe(ff_imm_oe),
    .o_halted(ff_halted), .o_illegal(ff_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected EXEC-cycle strobes, written straight from the opcode table.
  function automatic logic [12:0] expect_ctrl(input logic [7:0] op, input logic [3:0] f);
    int   nib = int'(op) / 16;
    logic a_w = 1, a_r = 1, b_w = 1, b_r = 1;
    logic [3:0] opc = 0;
    logic cin = 0, asel = 0, fsel = 0, ioe = 0, ill = 0;
    if (nib == 1) begin
      ioe = 1;
      if (op % 2 == 1) b_w = 0; else a_w = 0;
    end else if (nib == 2) begin
      if (op % 2 == 1) begin a_r = 0; b_w = 0; end
      else begin b_r = 0; a_w = 0; end
    end else if (nib == 3 || nib == 4) begin
      opc  = 4'(op % 16);
      asel = 1;
      fsel = 1;
      a_w  = 0;
      cin  = (nib == 4) ? f[1] : 1'b0;
    end else if (nib >= 7 && nib <= 14) begin
      ill = 1;
    end
    return {a_w, a_r, b_w, b_r, opc, cin, asel, fsel, ioe, ill};
  endfunction

  function automatic bit two_byte(input logic [7:0] op);
    int nib = int'(op) / 16;
    return nib == 1 || nib == 5 || nib == 6;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ack = 1'b0;
    @(negedge clk); #1;
    chk("rst_fetch_req", 32'(o_fetch_req), 0);
    chk("rst_pc", 32'(o_pc), 32'h00);
    chk("rst_ff_pc", 32'(ff_pc), 32'hFF);
    chk("rst_ctrl", 32'(ctrl_obs), 32'(IDLE));
    chk("rst_halted", 32'(o_halted), 0);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 8'h00;
  endtask

  // Hold the request for d cycles without ack, then ack with the given byte.
  task automatic fetch_byte(input int d, input logic [7:0] data);
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      chk("fetch_req", 32'(o_fetch_req), 1);
      chk("fetch_pc", 32'(o_pc), 32'(m_pc));
      chk("fetch_ctrl", 32'(ctrl_obs), 32'(IDLE));
      ack   = (i == d);
      instr = (i == d) ? data : 8'($urandom);
    end
    m_pc = m_pc + 8'd1;
  endtask

  task automatic exec_step(input logic [7:0] op, input logic [7:0] imm, input logic [3:0] f);
    int   nib = int'(op) / 16;
    logic c;
    @(negedge clk);
    flags = f;
    ack   = 1'($urandom);
    instr = 8'($urandom);
    #1;
    chk("exec_ctrl", 32'(ctrl_obs), 32'(expect_ctrl(op, f)));
    if (nib == 1) chk("exec_imm", 32'(o_imm_data), 32'(imm));
    chk("exec_pc", 32'(o_pc), 32'(m_pc));
    chk("exec_fetch_req", 32'(o_fetch_req), 0);
    case (op % 4)
      0: c = f[3];
      1: c = f[2];
      2: c = f[1];
      default: c = f[0];
    endcase
    if (op[2]) c = !c;
    if (nib == 5 || (nib == 6 && c)) m_pc = imm;
  endtask

  task automatic do_instr(input logic [7:0] op, input logic [7:0] imm,
                          input int d0, input int d1, input logic [3:0] f);
    fetch_byte(d0, op);
    if (two_byte(op)) fetch_byte(d1, imm);
    exec_step(op, imm, f);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    ack   = 1'b0;
    instr = 8'h00;
    flags = 4'h0;

    // LDI A, 0x5A with ack tied high
    do_reset();
    do_instr(8'h10, 8'h5A, 0, 0, 4'h0);
    chk("ldi_pc_after", 32'(m_pc), 32'h02);

    // NOP from RESET_PC=FF wraps the second instance to 00
    do_reset();
    do_instr(8'h00, 8'h00, 0, 0, 4'h0);
    chk("ff_pc_wrap", 32'(ff_pc), 32'h00);

    // ALU op 5 with slow memory, then ALUC with carry set and clear
    do_instr(8'h35, 8'h00, 4, 0, 4'b0010);
    do_instr(8'h4A, 8'h00, 1, 0, 4'b0010);
    do_instr(8'h4A, 8'h00, 0, 0, 4'b1101);

    // MOV both directions, LDI B
    do_instr(8'h20, 8'h00, 0, 0, 4'h0);
    do_instr(8'h21, 8'h00, 2, 0, 4'h0);
    do_instr(8'h11, 8'hC3, 0, 3, 4'h0);

    // JCC: taken on zr, then inverted condition not taken
    do_instr(8'h60, 8'h20, 0, 0, 4'b1000);
    chk("jcc_taken_pc", 32'(m_pc), 32'h20);
    do_instr(8'h64, 8'h40, 0, 0, 4'b1000);
    chk("jcc_not_taken_pc", 32'(m_pc), 32'h22);

    // JMP to FE, then JMP FE from FE (immediate fetched at FF)
    do_instr(8'h50, 8'hFE, 0, 0, 4'h0);
    do_instr(8'h50, 8'hFE, 1, 1, 4'h0);
    do_instr(8'h00, 8'h00, 0, 0, 4'h0);
    do_instr(8'h00, 8'h00, 0, 0, 4'h0);

    // Illegal opcode: single-cycle pulse, following fetch cycle checks it cleared
    do_instr(8'h80, 8'h00, 0, 0, 4'h0);
    do_instr(8'hE7, 8'h00, 1, 0, 4'h0);

    // Randomized stream excluding HALT
    for (int n = 0; n < 300; n++) begin
      logic [7:0] op;
      op = {4'($urandom_range(0, 14)), 4'($urandom)};
      do_instr(op, 8'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 4'($urandom));
    end

    // Reset in the middle of a MOV B<-A execute cycle
    fetch_byte(1, 8'h21);
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("mov_ctrl", 32'(ctrl_obs), 32'(expect_ctrl(8'h21, flags)));
    rst = 1'b1;
    #1;
    chk("abort_b_wrtn", 32'(o_b_wrtn), 1);
    chk("abort_a_rdn", 32'(o_a_rdn), 1);
    chk("abort_ctrl", 32'(ctrl_obs), 32'(IDLE));
    chk("abort_pc", 32'(o_pc), 32'h00);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 8'h00;

    // Reset while a fetch is pending
    do_instr(8'h00, 8'h00, 0, 0, 4'h0);
    @(negedge clk);
    ack = 1'b0;
    chk("pend_fetch_req", 32'(o_fetch_req), 1);
    rst = 1'b1;
    #1;
    chk("pend_abort_req", 32'(o_fetch_req), 0);
    chk("pend_abort_pc", 32'(o_pc), 32'h00);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 8'h00;

    // HALT: no further fetches, ack ignored, only reset leaves
    do_instr(8'h31, 8'h00, 0, 0, 4'h0);
    do_instr(8'hF0, 8'h00, 0, 0, 4'h0);
    repeat (5) begin
      @(negedge clk);
      ack   = 1'($urandom);
      instr = 8'($urandom);
      #1;
      chk("halt_halted", 32'(o_halted), 1);
      chk("halt_fetch_req", 32'(o_fetch_req), 0);
      chk("halt_ctrl", 32'(ctrl_obs), 32'(IDLE));
    end
    do_reset();
    do_instr(8'h00, 8'h00, 0, 0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
